// File: rtl/receive_queue.sv
// In-order request FIFO between the core's receive/avail issue port and the mailbox.
// Entries are presented oldest first over valid/ready; a pipeline flush discards all of them.
package receive_queue_pkg;

    typedef struct packed {
        logic [31:0] meta;
        logic [31:0] meta_mask;
        logic        is_avail;
        logic [4:0]  register;
        logic [7:0]  passthrough;
    } receive_queue_data_t;

endpackage

module receive_queue
    import receive_queue_pkg::*;
#(
    parameter int SIZE = 4,
    localparam int INDEX_WIDTH = $clog2(SIZE),
    localparam int COUNT_WIDTH = $clog2(SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   core_receive_queue_valid,
    output logic                   receive_queue_core_ready,
    input  receive_queue_data_t    core_receive_queue_data,
    output logic                   receive_queue_mailbox_valid,
    input  logic                   mailbox_receive_queue_ready,
    output receive_queue_data_t    receive_queue_mailbox_data,
    output logic [COUNT_WIDTH-1:0] receive_queue_count,
    output logic                   receive_queue_empty
);

    receive_queue_data_t    storage [SIZE];
    logic [INDEX_WIDTH-1:0] head;
    logic [INDEX_WIDTH-1:0] tail;
    logic [COUNT_WIDTH-1:0] count;
    logic                   enq;
    logic                   deq;

    // Explicit wrap so a non-power-of-two SIZE never walks into unused slots.
    function automatic logic [INDEX_WIDTH-1:0] next_ptr(input logic [INDEX_WIDTH-1:0] ptr);
        return (ptr == INDEX_WIDTH'(SIZE - 1)) ? '0 : ptr + INDEX_WIDTH'(1);
    endfunction

    // Ready looks only at registered occupancy and flush, never at the mailbox side.
    assign receive_queue_core_ready    = !flush && (count != COUNT_WIDTH'(SIZE));
    assign receive_queue_mailbox_valid = !flush && (count != '0);
    assign receive_queue_mailbox_data  = storage[head];
    assign receive_queue_count         = count;
    assign receive_queue_empty         = (count == '0);

    assign enq = core_receive_queue_valid && receive_queue_core_ready;
    assign deq = receive_queue_mailbox_valid && mailbox_receive_queue_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= next_ptr(tail);
            if (deq) head <= next_ptr(head);
            if (enq && !deq)
                count <= count + COUNT_WIDTH'(1);
            else if (deq && !enq)
                count <= count - COUNT_WIDTH'(1);
        end
    end

    // NOTE: storage has no reset; it is only read while count marks the slot valid.
    always_ff @(posedge clk) begin
        if (enq) storage[tail] <= core_receive_queue_data;
    end

endmodule

// File: tb/tb_receive_queue.sv
// Scoreboard bench for receive_queue: one SIZE=4 instance and one SIZE=3 instance,
// each checked against a reference occupancy model and an expected-data queue.
module tb_receive_queue;
    import receive_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                cv  [2];
    receive_queue_data_t cd  [2];
    logic                mr  [2];
    logic                fl  [2];
    logic                rdy [2];
    logic                vld [2];
    logic                emp [2];
    receive_queue_data_t md  [2];
    logic [2:0]          cnt [2];
    logic [2:0]          cnt4;
    logic [1:0]          cnt3;

    assign cnt[0] = cnt4;
    assign cnt[1] = {1'b0, cnt3};

    receive_queue #(.SIZE(4)) dut4 (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .flush                       (fl[0]),
        .core_receive_queue_valid    (cv[0]),
        .receive_queue_core_ready    (rdy[0]),
        .core_receive_queue_data     (cd[0]),
        .receive_queue_mailbox_valid (vld[0]),
        .mailbox_receive_queue_ready (mr[0]),
        .receive_queue_mailbox_data  (md[0]),
        .receive_queue_count         (cnt4),
        .receive_queue_empty         (emp[0])
    );

    receive_queue #(.SIZE(3)) dut3 (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .flush                       (fl[1]),
        .core_receive_queue_valid    (cv[1]),
        .receive_queue_core_ready    (rdy[1]),
        .core_receive_queue_data     (cd[1]),
        .receive_queue_mailbox_valid (vld[1]),
        .mailbox_receive_queue_ready (mr[1]),
        .receive_queue_mailbox_data  (md[1]),
        .receive_queue_count         (cnt3),
        .receive_queue_empty         (emp[1])
    );

    int vectors = 0;
    int miscompares = 0;
    int m_count [2] = '{0, 0};
    receive_queue_data_t sb0 [$];
    receive_queue_data_t sb1 [$];

    function automatic receive_queue_data_t mk(input int n);
        receive_queue_data_t d;
        logic [31:0] v;
        v = 32'(n);
        d.meta        = 32'hA000_0000 + v;
        d.meta_mask   = ~v;
        d.is_avail    = v[0];
        d.register    = v[4:0];
        d.passthrough = 8'(v * 3);
        return d;
    endfunction

    function automatic int size_of(input int sel);
        return (sel == 0) ? 4 : 3;
    endfunction

    // One cycle on instance sel: drive after negedge, compare handshakes and
    // any dequeued head against the scoreboard, then update the reference model.
    task automatic step(input int sel, input logic v, input receive_queue_data_t d,
                        input logic r, input logic f);
        logic er, ev;
        receive_queue_data_t exp;
        @(negedge clk);
        cv[sel] = v; cd[sel] = d; mr[sel] = r; fl[sel] = f;
        #1;
        er = !f && (m_count[sel] != size_of(sel));
        ev = !f && (m_count[sel] != 0);
        vectors++;
        if (rdy[sel] !== er) begin
            miscompares++;
            $display("FAIL core_ready[%0d]: got %b expected %b", sel, rdy[sel], er);
        end
        vectors++;
        if (vld[sel] !== ev) begin
            miscompares++;
            $display("FAIL mailbox_valid[%0d]: got %b expected %b", sel, vld[sel], ev);
        end
        vectors++;
        if (cnt[sel] !== 3'(m_count[sel])) begin
            miscompares++;
            $display("FAIL count[%0d]: got %0d expected %0d", sel, cnt[sel], m_count[sel]);
        end
        if (ev && r) begin
            exp = (sel == 0) ? sb0.pop_front() : sb1.pop_front();
            vectors++;
            if (md[sel] !== exp) begin
                miscompares++;
                $display("FAIL mailbox_data[%0d]: got %h expected %h", sel, md[sel], exp);
            end
        end
        if (f) begin
            if (sel == 0) sb0.delete(); else sb1.delete();
            m_count[sel] = 0;
        end else begin
            if (v && er) begin
                if (sel == 0) sb0.push_back(d); else sb1.push_back(d);
                m_count[sel]++;
            end
            if (ev && r) m_count[sel]--;
        end
        @(posedge clk);
        #1;
        cv[sel] = 1'b0; mr[sel] = 1'b0; fl[sel] = 1'b0;
    endtask

    task automatic drain(input int sel);
        while (m_count[sel] != 0) step(sel, 1'b0, mk(0), 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (rdy[s] !== 1'b1 || vld[s] !== 1'b0 || emp[s] !== 1'b1 || cnt[s] !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b emp=%b cnt=%0d expected 1 0 1 0",
                         s, rdy[s], vld[s], emp[s], cnt[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, mk(10 + i), 1'b0, 1'b0);
            vectors++;
            if (cnt[0] !== 3'(i + 1)) begin
                miscompares++;
                $display("FAIL fill_count: got %0d expected %0d", cnt[0], i + 1);
            end
        end
        vectors++;
        if (rdy[0] !== 1'b0 || vld[0] !== 1'b1 || md[0] !== mk(10)) begin
            miscompares++;
            $display("FAIL full_head: got rdy=%b vld=%b data=%h expected 0 1 %h",
                     rdy[0], vld[0], md[0], mk(10));
        end
        step(0, 1'b1, mk(14), 1'b0, 1'b0);
        vectors++;
        if (cnt[0] !== 3'd4 || md[0] !== mk(10)) begin
            miscompares++;
            $display("FAIL held_request: got cnt=%0d data=%h expected 4 %h", cnt[0], md[0], mk(10));
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) step(0, 1'b0, mk(0), 1'b1, 1'b0);
        vectors++;
        if (vld[0] !== 1'b0 || emp[0] !== 1'b1 || cnt[0] !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_empty: got vld=%b emp=%b cnt=%0d expected 0 1 0", vld[0], emp[0], cnt[0]);
        end
    endtask

    task automatic test_stream_wrap();
        step(0, 1'b1, mk(20), 1'b0, 1'b0);
        step(0, 1'b1, mk(21), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b1, mk(22 + i), 1'b1, 1'b0);
            vectors++;
            if (cnt[0] !== 3'd2) begin
                miscompares++;
                $display("FAIL stream_count: got %0d expected 2", cnt[0]);
            end
        end
        drain(0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(0, 1'b1, mk(40 + i), 1'b0, 1'b0);
        step(0, 1'b1, mk(43), 1'b1, 1'b1);
        vectors++;
        if (cnt[0] !== 3'd0 || emp[0] !== 1'b1 || vld[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got cnt=%0d emp=%b vld=%b expected 0 1 0", cnt[0], emp[0], vld[0]);
        end
        step(0, 1'b0, mk(0), 1'b1, 1'b0);
        step(0, 1'b1, mk(44), 1'b0, 1'b0);
        step(0, 1'b0, mk(0), 1'b1, 1'b0);
    endtask

    task automatic test_full_concurrent_deq();
        for (int i = 0; i < 4; i++) step(0, 1'b1, mk(50 + i), 1'b0, 1'b0);
        step(0, 1'b1, mk(54), 1'b1, 1'b0);
        vectors++;
        if (cnt[0] !== 3'd3 || rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reopen_ready: got cnt=%0d rdy=%b expected 3 1", cnt[0], rdy[0]);
        end
        step(0, 1'b1, mk(54), 1'b0, 1'b0);
        vectors++;
        if (cnt[0] !== 3'd4) begin
            miscompares++;
            $display("FAIL accept_after_reopen: got cnt=%0d expected 4", cnt[0]);
        end
        drain(0);
    endtask

    task automatic test_non_pow2();
        for (int i = 0; i < 3; i++) step(1, 1'b1, mk(60 + i), 1'b0, 1'b0);
        step(1, 1'b1, mk(63), 1'b0, 1'b0);
        step(1, 1'b0, mk(0), 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1, 1'b1, mk(70 + i), 1'b1, 1'b0);
            vectors++;
            if (cnt[1] > 3'd3 || cnt[1] !== 3'(m_count[1])) begin
                miscompares++;
                $display("FAIL size3_count: got %0d expected %0d", cnt[1], m_count[1]);
            end
        end
        drain(1);
    endtask

    task automatic test_reset_mid();
        step(0, 1'b1, mk(80), 1'b0, 1'b0);
        step(0, 1'b1, mk(81), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (cnt[0] !== 3'd0 || vld[0] !== 1'b0 || emp[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got cnt=%0d vld=%b emp=%b expected 0 0 1", cnt[0], vld[0], emp[0]);
        end
        sb0.delete();
        m_count[0] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b1, mk(82), 1'b0, 1'b0);
        drain(0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            cv[s] = 1'b0; cd[s] = '0; mr[s] = 1'b0; fl[s] = 1'b0;
        end
        test_reset();
        test_fill();
        test_drain();
        test_stream_wrap();
        test_flush();
        test_full_concurrent_deq();
        test_non_pow2();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/receive_queue.md
# receive_queue

In-order FIFO that buffers receive/avail requests issued by the core and presents them, oldest first, to the mailbox over a valid/ready handshake. It sits directly upstream of the mailbox: the core's receive-request port writes into it, and the mailbox dequeues when it can accept a new request. It decouples issue from mailbox resolution and discards all pending requests on a pipeline flush.

## Interface

Parameters:
- SIZE, default 4: number of entries; any integer ≥ 2, power of two not required.
- INDEX_WIDTH (localparam) = $clog2(SIZE): width of the head and tail pointers.
- COUNT_WIDTH (localparam) = $clog2(SIZE+1): width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; discards all entries.
- core_receive_queue_valid  in  1  core presents a request this cycle.
- receive_queue_core_ready  out  1  queue can accept a request this cycle.
- core_receive_queue_data  in  receive_queue_data_t  request (meta, meta_mask, is_avail, register, passthrough).
- receive_queue_mailbox_valid  out  1  head entry is valid.
- mailbox_receive_queue_ready  in  1  mailbox accepts the head entry.
- receive_queue_mailbox_data  out  receive_queue_data_t  head entry contents.
- receive_queue_count  out  COUNT_WIDTH  current occupancy.
- receive_queue_empty  out  1  occupancy is 0.

## Operation

- State:
  - storage array of SIZE × receive_queue_data_t;
  - head pointer (oldest entry) and tail pointer (next free slot), each INDEX_WIDTH bits;
  - count, COUNT_WIDTH bits.
- Enqueue fire: enq = core_receive_queue_valid & receive_queue_core_ready.
  - Writes the data to storage[tail].
  - Advances tail.
- Dequeue fire: deq = receive_queue_mailbox_valid & mailbox_receive_queue_ready.
  - Advances head.
- Pointer advance:
  - ptr == SIZE-1 wraps to 0; otherwise ptr+1.
  - No reliance on natural overflow, so non-power-of-two SIZE is correct.
- Count update:
  - +1 on enq only, −1 on deq only, unchanged on both or neither.
  - Never exceeds SIZE and never underflows.
- Outputs:
  - receive_queue_core_ready = !flush & (count != SIZE). It depends only on registered state and flush, with no combinational path from mailbox_receive_queue_ready.
  - receive_queue_mailbox_valid = !flush & (count != 0).
  - receive_queue_mailbox_data = storage[head] at all times; contents are don't-care when valid = 0.
  - receive_queue_empty = (count == 0).
  - receive_queue_count = count.
- Flush:
  - While flush = 1, both handshakes are suppressed (ready = 0, valid = 0), so no enq or deq fires.
  - The next edge sets head = tail = 0 and count = 0.
  - Flush takes priority over any concurrent core or mailbox activity.
- Storage is not reset and is never read while invalid.
- Ordering: strict FIFO. The queue never reorders, drops or duplicates entries except on flush.

## Timing

- Reset (rst_n = 0, asynchronous): head = 0, tail = 0, count = 0.
  - Outputs during reset: receive_queue_core_ready = 1 (when flush = 0), receive_queue_mailbox_valid = 0, receive_queue_empty = 1, receive_queue_count = 0.
  - Reset asserted mid-operation discards all entries immediately.
- Latency: an entry enqueued at edge N is presented to the mailbox in the cycle after edge N. There is no same-cycle empty bypass.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Full (count = SIZE): ready = 0, and the core must hold its data. A dequeue in that cycle re-opens ready in the next cycle, not the same one.
- Empty (count = 0): valid = 0. A simultaneous enqueue is not visible until the next cycle.
- Simultaneous enq and deq at 0 < count < SIZE: count unchanged, both pointers advance.
- Wrap-around: pointers wrap at SIZE-1 → 0 independently. Data order is preserved across the wrap.
- The mailbox may hold ready low indefinitely (for example, no CSU grant). The head entry and valid stay stable until deq.

## Test plan

- Reset then fill, SIZE = 4: enqueue A, B, C, D on consecutive cycles with mailbox ready = 0 → count goes 1, 2, 3, 4. After the 4th edge, ready = 0 and valid = 1 with data = A. A 5th request E is held and not accepted.
- Drain order: from full A–D, set mailbox ready = 1 for 4 cycles → data presented A, B, C, D, then valid = 0, empty = 1, count = 0.
- Streaming with wrap: keep 2 entries resident and perform 10 cycles of simultaneous enq/deq → count stays 2, pointers wrap at least twice, output sequence exactly matches input order.
- Flush while partially full: count = 3 and core valid = 1 in the flush cycle → during flush, ready = 0 and valid = 0. Next cycle count = 0, empty = 1, and the flushed request never appears at the mailbox.
- Full with concurrent dequeue: count = 4, deq fires, core valid = 1 → no enqueue that cycle. Next cycle count = 3, ready = 1, and the core's request is accepted on the following edge.
- Non-power-of-two SIZE = 3: 7 enqueue/dequeue pairs across a wrap → FIFO order is preserved, and count never exceeds 3.
